dco_afc_ctrl: RTL and testbench

Automatic frequency calibration (AFC) controller that drives the 9-bit `DCTRL` word of the VCO/DCO model.

- It runs a 9-step successive-approximation search on `DCTRL`.
- Each trial code is graded by counting prescaled DCO edges over a fixed window of reference cycles and comparing the count with the `FCW` target.
- It sits in the FREF domain ahead of the analog loop. It selects the coarse band before the loop closes on `VCTRL`.

---
 rtl/dco_afc_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dco_afc_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dco_afc_ctrl.sv
// Automatic frequency calibration: successive-approximation search of the DCO
// band word, grading each trial code by counting DCO/2 edges over a FREF window.
module dco_afc_ctrl #(
   parameter int DCTRL_W  = 9,
   parameter int CNT_W    = 16,
   parameter int WIN_LOG2 = 5,
   parameter int SETTLE   = 8
) (
   input  logic               FREF,
   input  logic               RST,
   input  logic               START,
   input  logic [15:0]        FCW,
   input  logic [CNT_W-1:0]   VCNT,
   output logic [DCTRL_W-1:0] DCTRL,
   output logic               BUSY,
   output logic               DONE,
   output logic [CNT_W-1:0]   MEAS_CNT
);

   localparam int WIN     = 1 << WIN_LOG2;
   localparam int CYC_MAX = (SETTLE > WIN) ? SETTLE : WIN;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);
   localparam int IDX_W   = (DCTRL_W > 1) ? $clog2(DCTRL_W) : 1;
   // Compare width must hold both the scaled count and the shifted target untruncated
   localparam int CMP_W   = ((CNT_W + 8) > (16 + WIN_LOG2)) ? (CNT_W + 8) : (16 + WIN_LOG2);

   localparam logic [DCTRL_W-1:0] DCTRL_RST = {1'b1, {(DCTRL_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]   IDX_TOP   = IDX_W'(DCTRL_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_MEAS   = 3'd2,
      ST_DECIDE = 3'd3,
      ST_FIN    = 3'd4
   } state_t;

   state_t             state_r, state_s;
   logic [15:0]        fcw_r, fcw_s;
   logic [CNT_W-1:0]   cnt_start_r, cnt_start_s;
   logic [CYC_W-1:0]   cyc_r, cyc_s;
   logic [IDX_W-1:0]   idx_r, idx_s;
   logic [DCTRL_W-1:0] dctrl_s;
   logic               busy_s;
   logic               done_s;
   logic [CNT_W-1:0]   meas_s;

   logic               last_settle_s;
   logic               last_meas_s;
   logic [CMP_W-1:0]   meas_ext_s;
   logic [CMP_W-1:0]   target_s;
   logic               too_fast_s;

   assign last_settle_s = (cyc_r == CYC_W'(SETTLE - 1));
   assign last_meas_s   = (cyc_r == CYC_W'(WIN - 1));
   assign meas_ext_s    = CMP_W'({MEAS_CNT, 8'h00});
   assign target_s      = CMP_W'(fcw_r) << WIN_LOG2;
   assign too_fast_s    = (meas_ext_s > target_s);

   // State and datapath registers
   always_ff @(posedge FREF or posedge RST) begin
      if (RST) begin
         state_r     <= ST_IDLE;
         fcw_r       <= 16'h0000;
         cnt_start_r <= {CNT_W{1'b0}};
         cyc_r       <= {CYC_W{1'b0}};
         idx_r       <= IDX_TOP;
         DCTRL       <= DCTRL_RST;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         MEAS_CNT    <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_s;
         fcw_r       <= fcw_s;
         cnt_start_r <= cnt_start_s;
         cyc_r       <= cyc_s;
         idx_r       <= idx_s;
         DCTRL       <= dctrl_s;
         BUSY        <= busy_s;
         DONE        <= done_s;
         MEAS_CNT    <= meas_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (START) state_s = ST_SETTLE;
            else       state_s = ST_IDLE;
         end
         ST_SETTLE: begin
            if (last_settle_s) state_s = ST_MEAS;
            else               state_s = ST_SETTLE;
         end
         ST_MEAS: begin
            if (last_meas_s) state_s = ST_DECIDE;
            else             state_s = ST_MEAS;
         end
         ST_DECIDE: begin
            if (idx_r == {IDX_W{1'b0}}) state_s = ST_FIN;
            else                        state_s = ST_SETTLE;
         end
         ST_FIN:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and search datapath
   always_comb begin
      fcw_s       = fcw_r;
      cnt_start_s = cnt_start_r;
      cyc_s       = cyc_r;
      idx_s       = idx_r;
      dctrl_s     = DCTRL;
      busy_s      = BUSY;
      done_s      = 1'b0;
      meas_s      = MEAS_CNT;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               fcw_s   = FCW;
               dctrl_s = DCTRL_RST;
               idx_s   = IDX_TOP;
               busy_s  = 1'b1;
               cyc_s   = {CYC_W{1'b0}};
            end else begin
               busy_s  = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (last_settle_s) begin
               cnt_start_s = VCNT;
               cyc_s       = {CYC_W{1'b0}};
            end else begin
               cyc_s       = cyc_r + CYC_W'(1);
            end
         end
         ST_MEAS: begin
            // Modular difference makes a counter wrap inside the window harmless
            if (last_meas_s) begin
               meas_s = VCNT - cnt_start_r;
               cyc_s  = {CYC_W{1'b0}};
            end else begin
               cyc_s  = cyc_r + CYC_W'(1);
            end
         end
         ST_DECIDE: begin
            if (too_fast_s) dctrl_s[idx_r] = 1'b0;
            else            dctrl_s[idx_r] = DCTRL[idx_r];
            if (idx_r != {IDX_W{1'b0}}) begin
               idx_s = idx_r - IDX_W'(1);
               dctrl_s[idx_r - IDX_W'(1)] = 1'b1;
            end else begin
               done_s = 1'b1;
               busy_s = 1'b0;
            end
         end
         ST_FIN: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
         default: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dco_afc_ctrl.sv
// Randomized self-checking bench for dco_afc_ctrl against a behavioural SAR
// reference model driven by a linear DCO model (44.0 + 0.1*DCTRL edges/cycle).
module tb_dco_afc_ctrl;

   logic        FREF = 1'b0;
   logic        RST;
   logic        START;
   logic [15:0] FCW;
   logic [15:0] VCNT;
   logic [8:0]  DCTRL;
   logic        BUSY;
   logic        DONE;
   logic [15:0] MEAS_CNT;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] vraw = 16'h0000;
   logic [15:0] vofs = 16'h0000;
   int          acc10 = 0;
   bit          const_mode = 1'b0;
   int          seq1 [9] = '{256, 128, 64, 32, 48, 56, 60, 62, 61};

   assign VCNT = vraw + vofs;

   always #5 FREF = ~FREF;

   dco_afc_ctrl dut (
      .FREF     (FREF),
      .RST      (RST),
      .START    (START),
      .FCW      (FCW),
      .VCNT     (VCNT),
      .DCTRL    (DCTRL),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .MEAS_CNT (MEAS_CNT)
   );

   // DCO model: advances the edge count just after each FREF edge
   always @(posedge FREF) begin
      #1;
      if (const_mode) begin
         vraw = vraw + 16'd50;
      end else begin
         acc10 = acc10 + 440 + int'(DCTRL);
         vraw  = vraw + 16'(acc10 / 10);
         acc10 = acc10 % 10;
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Runs one search from the current negedge; the reference model tracks the
   // trial code from the window counts it observes on VCNT.
   task automatic run_search(input logic [15:0] fcw, input int abort_at,
                             input int poke_at, input bit chk_seq,
                             output int final_code);
      int          code;
      int          idx;
      int          r;
      int          k;
      int          done_c;
      bit          busy_ok;
      logic [15:0] vc;
      logic [15:0] cs;
      logic [15:0] meas;
      code    = 256;
      idx     = 8;
      done_c  = -1;
      busy_ok = 1'b1;
      cs      = 16'h0;
      meas    = 16'h0;
      FCW     = fcw;
      START   = 1'b1;
      for (int c = 0; c < 370; c++) begin
         @(posedge FREF);
         vc = VCNT;
         r  = c % 41;
         if (r == 8)  cs = vc;
         if (r == 40) meas = vc - cs;
         @(negedge FREF);
         if (c == 0) begin
            START = 1'b0;
            check_eq("start_trial", int'(DCTRL), 256);
            check_eq("start_busy", int'(BUSY), 1);
         end
         if (c == abort_at) begin
            #3 RST = 1'b1;
            #1;
            check_eq("rst_dctrl", int'(DCTRL), 256);
            check_eq("rst_busy", int'(BUSY), 0);
            check_eq("rst_done", int'(DONE), 0);
            check_eq("rst_meas", int'(MEAS_CNT), 0);
            final_code = int'(DCTRL);
            return;
         end
         if (c == poke_at) begin
            START = 1'b1;
            FCW   = ~fcw;
         end else if (c == poke_at + 1) begin
            START = 1'b0;
            FCW   = fcw;
         end
         if (r == 40) begin
            k = c / 41;
            check_eq("meas_cnt", int'(MEAS_CNT), int'(meas));
            check_eq("trial", int'(DCTRL), code);
            if (chk_seq) check_eq("trial_seq", int'(DCTRL), seq1[k]);
         end
         if (r == 0 && c > 0) begin
            if (int'(meas) * 256 > int'(fcw) * 32) code = code & ~(1 << idx);
            if (idx > 0) begin
               idx  = idx - 1;
               code = code | (1 << idx);
            end
            check_eq("decide", int'(DCTRL), code);
         end
         if (c < 369 && (BUSY !== 1'b1 || DONE !== 1'b0)) busy_ok = 1'b0;
         if (DONE === 1'b1 && done_c < 0) done_c = c + 1;
      end
      check_eq("busy_through", int'(busy_ok), 1);
      check_eq("done_cycle", done_c, 370);
      check_eq("fin_busy", int'(BUSY), 0);
      check_eq("final_code", int'(DCTRL), code);
      final_code = code;
   endtask

   initial begin
      int          res;
      int          dones;
      logic [15:0] f;
      RST   = 1'b1;
      START = 1'b0;
      FCW   = 16'h0000;
      repeat (3) @(negedge FREF);
      check_eq("reset_dctrl", int'(DCTRL), 256);
      check_eq("reset_busy", int'(BUSY), 0);
      check_eq("reset_done", int'(DONE), 0);
      check_eq("reset_meas", int'(MEAS_CNT), 0);
      RST = 1'b0;
      repeat (2) @(negedge FREF);
      check_eq("idle_hold", int'(DCTRL), 256);

      // Nominal
      run_search(16'h3222, -1, -1, 1'b1, res);
      check_eq("t1_final", res, 61);
      repeat (2) @(negedge FREF);
      check_eq("t1_hold", int'(DCTRL), 61);

      // Saturation low and high
      run_search(16'h2000, -1, -1, 1'b0, res);
      check_eq("sat_low", int'(DCTRL), 0);
      @(negedge FREF);
      run_search(16'h7000, -1, -1, 1'b0, res);
      check_eq("sat_high", int'(DCTRL), 511);
      @(negedge FREF);

      // Counter wrap inside the first window, exact-equality windows
      const_mode = 1'b1;
      vofs = 16'hFFF0 - 16'd1000 - vraw;
      run_search(16'h3200, -1, -1, 1'b0, res);
      check_eq("wrap_meas", int'(MEAS_CNT), 1600);
      check_eq("wrap_final", int'(DCTRL), 511);
      const_mode = 1'b0;
      @(negedge FREF);

      // START and FCW disturbed mid-search
      run_search(16'h3222, -1, 100, 1'b1, res);
      check_eq("busy_start_final", int'(DCTRL), 61);
      dones = 0;
      repeat (60) begin
         @(negedge FREF);
         if (DONE === 1'b1) dones++;
      end
      check_eq("no_second_done", dones, 0);
      check_eq("no_second_busy", int'(BUSY), 0);

      // Reset mid-search, then a clean search
      run_search(16'h3222, 150, -1, 1'b0, res);
      @(negedge FREF);
      check_eq("rst_hold_dctrl", int'(DCTRL), 256);
      RST = 1'b0;
      repeat (2) @(negedge FREF);
      check_eq("rst_release_busy", int'(BUSY), 0);
      run_search(16'h3222, -1, -1, 1'b1, res);
      check_eq("after_rst_final", int'(DCTRL), 61);

      // Back-to-back: START in the FIN cycle is ignored, next cycle accepted
      START = 1'b1;
      FCW   = 16'h3222;
      @(negedge FREF);
      check_eq("fin_start_busy", int'(BUSY), 0);
      check_eq("fin_start_dctrl", int'(DCTRL), 61);
      run_search(16'h3222, -1, -1, 1'b1, res);
      check_eq("b2b_final", int'(DCTRL), 61);
      @(negedge FREF);

      // Randomized targets and counter offsets
      for (int i = 0; i < 4; i++) begin
         f    = 16'($urandom_range(16'h2000, 16'h7000));
         vofs = 16'($urandom);
         @(negedge FREF);
         run_search(f, -1, -1, 1'b0, res);
         @(negedge FREF);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
